vcfg_sequencer: RTL and testbench

Owns the vector configuration state: vl, vtype and vstart. It executes vsetvli, vsetivli and vsetvl, along with vector-CSR reads and vstart writes, that the scalar dispatcher forwards over a valid/ready request channel. Any instruction that modifies configuration is held until the vector backend has drained, so in-flight vector instructions never see a vtype/vl change. Results go back to the dispatcher over a valid/ready response channel.

---
 rtl/vcfg_sequencer.sv | 274 +++++++++++++++++++++++++++
 tb/tb_vcfg_sequencer.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vcfg_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vcfg_sequencer                                             |
// | Description : Owns vl / vtype / vstart. Executes vsetvli, vsetivli,      |
// |               vsetvl, vector-CSR reads and vstart writes from the        |
// |               dispatcher. Configuration changes wait for backend drain.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module vcfg_sequencer #(
   parameter int VLEN    = 4096,
   parameter int ELEN    = 64,
   parameter int VlWidth = $clog2(VLEN) + 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [31:0]        req_instr_i,
   input  logic [63:0]        req_rs1_i,
   input  logic [63:0]        req_rs2_i,
   input  logic               vec_busy_i,
   output logic               resp_valid_o,
   input  logic               resp_ready_i,
   output logic [63:0]        resp_result_o,
   output logic               resp_illegal_o,
   output logic [VlWidth-1:0] vl_o,
   output logic [8:0]         vtype_o,
   output logic [VlWidth-1:0] vstart_o
);

   localparam logic [6:0]  c_op_v       = 7'b1010111;
   localparam logic [6:0]  c_op_system  = 7'b1110011;
   localparam logic [2:0]  c_f3_opcfg   = 3'b111;
   localparam logic [2:0]  c_f3_csrrw   = 3'b001;
   localparam logic [2:0]  c_f3_csrrs   = 3'b010;
   localparam logic [11:0] c_csr_vstart = 12'h008;
   localparam logic [11:0] c_csr_vl     = 12'hC20;
   localparam logic [11:0] c_csr_vtype  = 12'hC21;
   localparam logic [11:0] c_csr_vlenb  = 12'hC22;
   localparam logic [2:0]  c_lmul_rsvd  = 3'b100;
   localparam logic [2:0]  c_lmul_f8    = 3'b101;
   localparam logic [2:0]  c_lmul_f4    = 3'b110;
   localparam logic [2:0]  c_lmul_f2    = 3'b111;
   localparam logic [2:0]  c_max_vsew   = 3'($clog2(ELEN) - 3);
   localparam logic [63:0] c_vlen       = 64'(VLEN);
   localparam logic [63:0] c_vlenb      = 64'(VLEN / 8);
   localparam logic [8:0]  c_vtype_vill = 9'h100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic               w_accept;
   logic               w_commit;

   logic [31:0]        r_instr;
   logic [63:0]        r_rs1;
   logic [63:0]        r_rs2;
   logic               r_is_vstart_wr;
   logic [VlWidth-1:0] r_vl;
   logic [8:0]         r_vtype;
   logic [VlWidth-1:0] r_vstart;
   logic [63:0]        r_resp_result;
   logic               r_resp_illegal;

   // ---------------- request decode (live inputs, used at acceptance) -------
   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [4:0]  w_rs1f;
   logic [11:0] w_csr;
   logic        w_is_vset;
   logic        w_is_csr_read;
   logic        w_is_vstart_wr;
   logic        w_is_illegal;
   logic        w_needs_drain;
   logic [63:0] w_read_value;

   assign w_opcode = req_instr_i[6:0];
   assign w_funct3 = req_instr_i[14:12];
   assign w_rs1f   = req_instr_i[19:15];
   assign w_csr    = req_instr_i[31:20];

   // Classify the incoming instruction and prepare the CSR read value
   always_comb begin
      w_is_vset      = 1'b0;
      w_is_csr_read  = 1'b0;
      w_is_vstart_wr = 1'b0;
      w_read_value   = '0;
      if (w_opcode == c_op_v && w_funct3 == c_f3_opcfg) begin
         w_is_vset = (req_instr_i[31] == 1'b0) || (req_instr_i[31:30] == 2'b11) ||
                     (req_instr_i[31:25] == 7'b1000000);
      end
      if (w_opcode == c_op_system) begin
         if (w_funct3 == c_f3_csrrs && w_rs1f == 5'd0) begin
            w_is_csr_read = 1'b1;
            case (w_csr)
               c_csr_vl:     w_read_value = 64'(r_vl);
               c_csr_vtype:  w_read_value = {r_vtype[8], 55'd0, r_vtype[7:0]};
               c_csr_vlenb:  w_read_value = c_vlenb;
               c_csr_vstart: w_read_value = 64'(r_vstart);
               default:      w_is_csr_read = 1'b0;
            endcase
         end
         w_is_vstart_wr = (w_funct3 == c_f3_csrrw) && (w_csr == c_csr_vstart);
      end
   end

   assign w_needs_drain = w_is_vset | w_is_vstart_wr;
   assign w_is_illegal  = ~(w_is_vset | w_is_csr_read | w_is_vstart_wr);

   // ---------------- configuration computation (registered request) --------
   logic [4:0]  w_cfg_rs1f;
   logic [4:0]  w_cfg_rd;
   logic [63:0] w_vtype_raw;
   logic        w_high_bad;
   logic [63:0] w_avl;
   logic [2:0]  w_vsew;
   logic [2:0]  w_vlmul;
   logic        w_vill;
   logic [63:0] w_vlmax_base;
   logic [63:0] w_vlmax;
   logic [63:0] w_new_vl;

   assign w_cfg_rs1f = r_instr[19:15];
   assign w_cfg_rd   = r_instr[11:7];

   // Extract requested vtype, reserved-bit violations and AVL per instruction form
   always_comb begin
      w_vtype_raw = '0;
      w_high_bad  = 1'b0;
      w_avl       = '0;
      if (r_instr[31:30] == 2'b11) begin
         w_vtype_raw = 64'(r_instr[29:20]);
         w_high_bad  = |r_instr[29:28];
         w_avl       = 64'(w_cfg_rs1f);
      end else begin
         if (r_instr[31] == 1'b0) begin
            w_vtype_raw = 64'(r_instr[30:20]);
            w_high_bad  = |r_instr[30:28];
         end else begin
            w_vtype_raw = r_rs2;
            w_high_bad  = |r_rs2[62:8];
         end
         if (w_cfg_rs1f != 5'd0) begin
            w_avl = r_rs1;
         end else if (w_cfg_rd != 5'd0) begin
            w_avl = '1;
         end else begin
            w_avl = 64'(r_vl);
         end
      end
   end

   assign w_vsew  = w_vtype_raw[5:3];
   assign w_vlmul = w_vtype_raw[2:0];

   // Fractional LMUL needs SEW <= ELEN*LMUL, so each fraction caps the legal SEW
   always_comb begin
      w_vill = w_high_bad || (w_vsew > c_max_vsew) || (w_vlmul == c_lmul_rsvd) ||
               ((w_vlmul == c_lmul_f8) && (w_vsew > 3'd0)) ||
               ((w_vlmul == c_lmul_f4) && (w_vsew > 3'd1)) ||
               ((w_vlmul == c_lmul_f2) && (w_vsew > 3'd2));
   end

   assign w_vlmax_base = c_vlen >> (6'd3 + {3'd0, w_vsew});

   // Scale the per-register element count by LMUL
   always_comb begin
      w_vlmax = w_vlmax_base;
      case (w_vlmul)
         3'b001:  w_vlmax = w_vlmax_base << 1;
         3'b010:  w_vlmax = w_vlmax_base << 2;
         3'b011:  w_vlmax = w_vlmax_base << 3;
         3'b101:  w_vlmax = w_vlmax_base >> 3;
         3'b110:  w_vlmax = w_vlmax_base >> 2;
         3'b111:  w_vlmax = w_vlmax_base >> 1;
         default: w_vlmax = w_vlmax_base;
      endcase
   end

   assign w_new_vl = w_vill ? 64'd0 : ((w_avl < w_vlmax) ? w_avl : w_vlmax);

   // ---------------- control FSM ----------------
   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and handshake decode
   always_comb begin
      w_state_nxt = r_state;
      req_ready_o = 1'b0;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready_o = 1'b1;
            w_accept    = req_valid_i;
            if (req_valid_i) begin
               w_state_nxt = w_needs_drain ? ST_DRAIN : ST_RESP;
            end
         end
         ST_DRAIN: begin
            if (!vec_busy_i) begin
               w_commit    = 1'b1;
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_ready_i) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Capture the request on acceptance and commit configuration after drain
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_instr        <= '0;
         r_rs1          <= '0;
         r_rs2          <= '0;
         r_is_vstart_wr <= 1'b0;
         r_vl           <= '0;
         r_vtype        <= c_vtype_vill;
         r_vstart       <= '0;
         r_resp_result  <= '0;
         r_resp_illegal <= 1'b0;
      end else begin
         if (w_accept) begin
            r_instr        <= req_instr_i;
            r_rs1          <= req_rs1_i;
            r_rs2          <= req_rs2_i;
            r_is_vstart_wr <= w_is_vstart_wr;
            r_resp_illegal <= w_is_illegal;
            r_resp_result  <= w_is_csr_read ? w_read_value : 64'd0;
         end
         if (w_commit) begin
            if (r_is_vstart_wr) begin
               r_vstart      <= r_rs1[VlWidth-1:0];
               r_resp_result <= 64'(r_vstart);
            end else begin
               r_vl          <= w_new_vl[VlWidth-1:0];
               r_vtype       <= w_vill ? c_vtype_vill : {1'b0, w_vtype_raw[7:0]};
               r_vstart      <= '0;
               r_resp_result <= w_new_vl;
            end
         end
      end
   end

   assign resp_valid_o   = (r_state == ST_RESP);
   assign resp_result_o  = r_resp_result;
   assign resp_illegal_o = r_resp_illegal;
   assign vl_o           = r_vl;
   assign vtype_o        = r_vtype;
   assign vstart_o       = r_vstart;

   // Instruction fields that carry no information for this unit
   logic w_unused;
   assign w_unused = ^{req_instr_i[11:7], r_instr[14:12], r_instr[6:0], r_rs2[63]};

endmodule
`default_nettype wire

// File: tb/tb_vcfg_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_vcfg_sequencer                                          |
// | Description : Self-checking bench for vcfg_sequencer with a behavioural  |
// |               model of vl / vtype / vstart.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_vcfg_sequencer;

   localparam int VLEN = 4096;
   localparam int ELEN = 64;
   localparam int VLW  = 13;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           req_valid = 1'b0;
   logic           req_ready;
   logic [31:0]    req_instr = '0;
   logic [63:0]    req_rs1 = '0;
   logic [63:0]    req_rs2 = '0;
   logic           vec_busy = 1'b0;
   logic           resp_valid;
   logic           resp_ready = 1'b1;
   logic [63:0]    resp_result;
   logic           resp_illegal;
   logic [VLW-1:0] vl;
   logic [8:0]     vtype;
   logic [VLW-1:0] vstart;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   logic [63:0] m_vl;
   logic [63:0] m_vstart;
   logic        m_vill;
   logic [7:0]  m_vtype8;

   vcfg_sequencer #(.VLEN(VLEN), .ELEN(ELEN), .VlWidth(VLW)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_instr_i    (req_instr),
      .req_rs1_i      (req_rs1),
      .req_rs2_i      (req_rs2),
      .vec_busy_i     (vec_busy),
      .resp_valid_o   (resp_valid),
      .resp_ready_i   (resp_ready),
      .resp_result_o  (resp_result),
      .resp_illegal_o (resp_illegal),
      .vl_o           (vl),
      .vtype_o        (vtype),
      .vstart_o       (vstart)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1);
   end

   // ---------------- instruction builders ----------------
   function automatic logic [31:0] f_vsetvli(input logic [4:0] rd, input logic [4:0] rs1f,
                                             input logic [10:0] zimm);
      return {1'b0, zimm, rs1f, 3'b111, rd, 7'b1010111};
   endfunction

   function automatic logic [31:0] f_vsetivli(input logic [4:0] rd, input logic [4:0] uimm,
                                              input logic [9:0] zimm);
      return {2'b11, zimm, uimm, 3'b111, rd, 7'b1010111};
   endfunction

   function automatic logic [31:0] f_vsetvl(input logic [4:0] rd, input logic [4:0] rs1f,
                                            input logic [4:0] rs2f);
      return {7'b1000000, rs2f, rs1f, 3'b111, rd, 7'b1010111};
   endfunction

   function automatic logic [31:0] f_csr(input logic [11:0] csr, input logic [4:0] rs1f,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {csr, rs1f, f3, rd, 7'b1110011};
   endfunction

   // ---------------- reference model ----------------
   task automatic model_reset;
      m_vl     = 64'd0;
      m_vstart = 64'd0;
      m_vill   = 1'b1;
      m_vtype8 = 8'd0;
   endtask

   // VLMAX = VLEN * LMUL / SEW with LMUL kept as a num/den fraction
   task automatic model_vset(input logic [31:0] instr, input logic [63:0] rs1v,
                             input logic [63:0] rs2v, output logic [63:0] exp_res);
      logic [63:0] vt;
      logic [63:0] avl;
      logic [63:0] vlmax;
      logic        hi_bad;
      logic [2:0]  sewc;
      logic [2:0]  lmc;
      int          sew;
      int          num;
      int          den;
      logic [4:0]  rs1f;
      logic [4:0]  rd;
      rs1f = instr[19:15];
      rd   = instr[11:7];
      if (instr[31] == 1'b0) begin
         vt     = 64'(instr[30:20]);
         hi_bad = (vt >> 8) != 0;
      end else if (instr[31:30] == 2'b11) begin
         vt     = 64'(instr[29:20]);
         hi_bad = (vt >> 8) != 0;
      end else begin
         vt     = rs2v;
         hi_bad = ((rs2v << 1) >> 9) != 0;
      end
      sewc = vt[5:3];
      lmc  = vt[2:0];
      sew  = 8 << sewc;
      if (lmc < 3'd4) begin
         num = 1 << lmc;
         den = 1;
      end else begin
         num = 1;
         den = 1 << (8 - lmc);
      end
      if (instr[31:30] == 2'b11) avl = 64'(rs1f);
      else if (rs1f != 5'd0)     avl = rs1v;
      else if (rd != 5'd0)       avl = '1;
      else                       avl = m_vl;
      if (!hi_bad && sew <= ELEN && lmc != 3'd4 && sew * den <= ELEN) begin
         vlmax    = 64'((VLEN * num) / (sew * den));
         m_vl     = (avl < vlmax) ? avl : vlmax;
         m_vill   = 1'b0;
         m_vtype8 = vt[7:0];
      end else begin
         m_vl     = 64'd0;
         m_vill   = 1'b1;
         m_vtype8 = 8'd0;
      end
      m_vstart = 64'd0;
      exp_res  = m_vl;
   endtask

   function automatic logic [63:0] model_read(input logic [11:0] csr);
      case (csr)
         12'hC20: return m_vl;
         12'hC21: return {m_vill, 55'd0, m_vtype8};
         12'hC22: return 64'(VLEN / 8);
         default: return m_vstart;
      endcase
   endfunction

   // Drive one request (DUT idle, called just after a clock edge) and wait
   // for its response; lat = cycles from acceptance edge, -1 on timeout.
   task automatic send(input logic [31:0] instr, input logic [63:0] rs1v, input logic [63:0] rs2v,
                       output logic [63:0] res, output logic ill, output int lat);
      req_valid = 1'b1;
      req_instr = instr;
      req_rs1   = rs1v;
      req_rs2   = rs2v;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      res = resp_result;
      ill = resp_illegal;
      if (!resp_valid) lat = -1;
      @(posedge clk); #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      n_checks++;
      if (vtype !== 9'h100 || vl !== '0 || vstart !== '0) begin
         $display("FAIL reset_cfg: got vtype=%h vl=%0d vstart=%0d want 100/0/0", vtype, vl, vstart);
      end else n_pass++;
      n_checks++;
      if (resp_valid !== 1'b0 || resp_illegal !== 1'b0 || resp_result !== 64'd0) begin
         $display("FAIL reset_resp: got valid=%b ill=%b res=%h want 0/0/0", resp_valid, resp_illegal, resp_result);
      end else n_pass++;
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready);
      else n_pass++;
   endtask

   task automatic test_vsetvli;
      logic [63:0] exp;
      logic [63:0] res;
      logic        ill;
      int          lat;
      // e32 m1, AVL 100 from x6
      model_vset(f_vsetvli(5'd5, 5'd6, 11'h010), 64'd100, 64'd0, exp);
      send(f_vsetvli(5'd5, 5'd6, 11'h010), 64'd100, 64'd0, res, ill, lat);
      n_checks++;
      if (res !== 64'd100 || ill !== 1'b0 || lat !== 2) begin
         $display("FAIL vsetvli_e32m1: got res=%0d ill=%b lat=%0d want 100/0/2", res, ill, lat);
      end else n_pass++;
      n_checks++;
      if (vl !== 13'd100 || vtype !== 9'h010 || exp !== 64'd100) begin
         $display("FAIL vsetvli_e32m1_state: got vl=%0d vtype=%h model=%0d want 100/010", vl, vtype, exp);
      end else n_pass++;
      // e8 m8, rs1=x0 rd!=0 -> AVL all ones -> VLMAX
      model_vset(f_vsetvli(5'd5, 5'd0, 11'h003), 64'd0, 64'd0, exp);
      send(f_vsetvli(5'd5, 5'd0, 11'h003), 64'd0, 64'd0, res, ill, lat);
      n_checks++;
      if (res !== 64'd4096 || vl !== 13'd4096 || vtype !== 9'h003) begin
         $display("FAIL vsetvli_e8m8: got res=%0d vl=%0d vtype=%h want 4096/4096/003", res, vl, vtype);
      end else n_pass++;
      // e64 mf2 is reserved -> vill
      model_vset(f_vsetvli(5'd5, 5'd0, 11'h01F), 64'd0, 64'd0, exp);
      send(f_vsetvli(5'd5, 5'd0, 11'h01F), 64'd0, 64'd0, res, ill, lat);
      n_checks++;
      if (res !== 64'd0 || ill !== 1'b0 || vl !== '0 || vtype !== 9'h100) begin
         $display("FAIL vsetvli_vill: got res=%0d ill=%b vl=%0d vtype=%h want 0/0/0/100", res, ill, vl, vtype);
      end else n_pass++;
   endtask

   task automatic test_drain;
      logic [63:0]    exp;
      logic [31:0]    ins;
      logic [VLW-1:0] old_vl;
      logic [8:0]     old_vt;
      ins    = f_vsetivli(5'd5, 5'd7, 10'h008);
      old_vl = m_vl[VLW-1:0];
      old_vt = {m_vill, m_vtype8};
      model_vset(ins, 64'd0, 64'd0, exp);
      vec_busy  = 1'b1;
      req_valid = 1'b1;
      req_instr = ins;
      req_rs1   = 64'd0;
      req_rs2   = 64'd0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
         end
         n_checks++;
         if (resp_valid !== 1'b0 || vl !== old_vl || vtype !== old_vt) begin
            $display("FAIL drain_hold[%0d]: got valid=%b vl=%0d vtype=%h want 0/%0d/%h", i, resp_valid, vl, vtype, old_vl, old_vt);
         end else n_pass++;
      end
      vec_busy = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (resp_valid !== 1'b1 || vl !== 13'd7 || resp_result !== 64'd7 || exp !== 64'd7) begin
         $display("FAIL drain_release: got valid=%b vl=%0d res=%0d want 1/7/7", resp_valid, vl, resp_result);
      end else n_pass++;
      n_checks++;
      if (vtype !== 9'h008 || vstart !== '0) begin
         $display("FAIL drain_vtype: got vtype=%h vstart=%0d want 008/0", vtype, vstart);
      end else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_csr;
      logic [63:0] res;
      logic        ill;
      int          lat;
      vec_busy = 1'b1;
      send(f_csr(12'hC22, 5'd0, 3'b010, 5'd5), 64'd0, 64'd0, res, ill, lat);
      n_checks++;
      if (res !== 64'd512 || ill !== 1'b0 || lat !== 1) begin
         $display("FAIL csr_vlenb: got res=%0d ill=%b lat=%0d want 512/0/1", res, ill, lat);
      end else n_pass++;
      send(f_csr(12'hC20, 5'd6, 3'b001, 5'd0), 64'd55, 64'd0, res, ill, lat);
      n_checks++;
      if (res !== 64'd0 || ill !== 1'b1 || lat !== 1) begin
         $display("FAIL csr_write_vl: got res=%0d ill=%b lat=%0d want 0/1/1", res, ill, lat);
      end else n_pass++;
      n_checks++;
      if (vl !== m_vl[VLW-1:0] || vtype !== {m_vill, m_vtype8}) begin
         $display("FAIL csr_write_vl_state: got vl=%0d vtype=%h want %0d/%h", vl, vtype, m_vl, {m_vill, m_vtype8});
      end else n_pass++;
      vec_busy = 1'b0;
   endtask

   task automatic test_backpressure;
      logic [63:0] r0;
      logic        i0;
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_instr  = f_csr(12'hC20, 5'd0, 3'b010, 5'd5);
      @(posedge clk); #1;
      req_instr = f_csr(12'hC21, 5'd0, 3'b010, 5'd7);
      n_checks++;
      if (resp_valid !== 1'b1 || resp_result !== m_vl || resp_illegal !== 1'b0) begin
         $display("FAIL bp_first: got valid=%b res=%0d ill=%b want 1/%0d/0", resp_valid, resp_result, resp_illegal, m_vl);
      end else n_pass++;
      r0 = resp_result;
      i0 = resp_illegal;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (resp_valid !== 1'b1 || resp_result !== r0 || resp_illegal !== i0 || req_ready !== 1'b0) begin
            $display("FAIL bp_hold[%0d]: got valid=%b res=%0d ill=%b ready=%b want 1/%0d/%b/0", i, resp_valid, resp_result, resp_illegal, req_ready, r0, i0);
         end else n_pass++;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         $display("FAIL bp_release: got ready=%b valid=%b want 1/0", req_ready, resp_valid);
      end else n_pass++;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_checks++;
      if (resp_valid !== 1'b1 || resp_result !== model_read(12'hC21) || resp_illegal !== 1'b0) begin
         $display("FAIL bp_second: got valid=%b res=%h want 1/%h", resp_valid, resp_result, model_read(12'hC21));
      end else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      logic [63:0] exp;
      logic [63:0] res;
      logic        ill;
      int          lat;
      exp = m_vstart;
      m_vstart = 64'd9;
      send(f_csr(12'h008, 5'd6, 3'b001, 5'd5), 64'd9, 64'd0, res, ill, lat);
      n_checks++;
      if (res !== exp || ill !== 1'b0 || lat !== 2 || vstart !== 13'd9) begin
         $display("FAIL vstart_write: got res=%0d ill=%b lat=%0d vstart=%0d want %0d/0/2/9", res, ill, lat, vstart, exp);
      end else n_pass++;
      vec_busy  = 1'b1;
      req_valid = 1'b1;
      req_instr = f_vsetvli(5'd5, 5'd6, 11'h011);
      req_rs1   = 64'd200;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      model_reset();
      n_checks++;
      if (vtype !== 9'h100 || vl !== '0 || vstart !== '0 || resp_valid !== 1'b0 ||
          resp_result !== 64'd0 || resp_illegal !== 1'b0) begin
         $display("FAIL reset_mid: got vtype=%h vl=%0d vstart=%0d valid=%b res=%0d ill=%b want reset values", vtype, vl, vstart, resp_valid, resp_result, resp_illegal);
      end else n_pass++;
      @(posedge clk); #1;
      rst      = 1'b0;
      vec_busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (resp_valid !== 1'b0 || req_ready !== 1'b1 || vl !== '0 || vtype !== 9'h100) begin
            $display("FAIL reset_mid_after[%0d]: got valid=%b ready=%b vl=%0d vtype=%h want 0/1/0/100", i, resp_valid, req_ready, vl, vtype);
         end else n_pass++;
      end
   endtask

   task automatic test_random;
      logic [63:0] exp;
      logic [63:0] res;
      logic        ill;
      int          lat;
      int          exp_lat;
      logic        exp_ill;
      logic [31:0] ins;
      logic [63:0] rs1v;
      logic [63:0] rs2v;
      logic [4:0]  rd;
      logic [4:0]  rs1f;
      logic [7:0]  vbyte;
      logic        hb;
      logic [11:0] csr;
      for (int it = 0; it < 80; it++) begin
         rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         rs1f  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         vbyte = 8'($urandom);
         vbyte[5:3] = 3'($urandom_range(0, 4));
         hb    = ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 2))
            0:       rs1v = 64'($urandom_range(0, 600));
            1:       rs1v = {$urandom, $urandom};
            default: rs1v = 64'(VLEN >> $urandom_range(0, 9));
         endcase
         if (rs1f == 5'd0) rs1v = 64'd0;
         rs2v     = 64'd0;
         exp_ill  = 1'b0;
         exp_lat  = 2;
         vec_busy = 1'b0;
         case ($urandom_range(0, 5))
            0: begin
               ins = f_vsetvli(rd, rs1f, {hb ? 3'($urandom_range(1, 7)) : 3'd0, vbyte});
               model_vset(ins, rs1v, rs2v, exp);
            end
            1: begin
               ins = f_vsetivli(rd, rs1f, {hb ? 2'($urandom_range(1, 3)) : 2'd0, vbyte});
               model_vset(ins, rs1v, rs2v, exp);
            end
            2: begin
               rs2v = {56'd0, vbyte};
               if (hb) rs2v = rs2v | (64'd1 << $urandom_range(8, 62));
               ins = f_vsetvl(rd, rs1f, 5'($urandom));
               model_vset(ins, rs1v, rs2v, exp);
            end
            3: begin
               case ($urandom_range(0, 3))
                  0:       csr = 12'hC20;
                  1:       csr = 12'hC21;
                  2:       csr = 12'hC22;
                  default: csr = 12'h008;
               endcase
               ins      = f_csr(csr, 5'd0, 3'b010, rd);
               exp      = model_read(csr);
               exp_lat  = 1;
               vec_busy = 1'($urandom);
            end
            4: begin
               ins      = f_csr(12'h008, rs1f, 3'b001, rd);
               exp      = m_vstart;
               m_vstart = rs1v & 64'h1FFF;
            end
            default: begin
               case ($urandom_range(0, 4))
                  0:       ins = f_csr(12'hC20 + 12'($urandom_range(0, 2)), rs1f, 3'b001, rd);
                  1:       ins = f_csr(12'hC20, 5'($urandom_range(1, 31)), 3'b010, rd);
                  2:       ins = {7'b1000001, 5'($urandom), rs1f, 3'b111, rd, 7'b1010111};
                  3:       ins = {12'($urandom), rs1f, 3'b000, rd, 7'b1010111};
                  default: ins = f_csr(12'h300, 5'd0, 3'b010, rd);
               endcase
               exp      = 64'd0;
               exp_ill  = 1'b1;
               exp_lat  = 1;
               vec_busy = 1'($urandom);
            end
         endcase
         send(ins, rs1v, rs2v, res, ill, lat);
         vec_busy = 1'b0;
         n_checks++;
         if (res !== exp || ill !== exp_ill || lat !== exp_lat) begin
            $display("FAIL rand_resp[%0d] instr=%h: got res=%h ill=%b lat=%0d want %h/%b/%0d", it, ins, res, ill, lat, exp, exp_ill, exp_lat);
         end else n_pass++;
         n_checks++;
         if (vl !== m_vl[VLW-1:0] || vtype !== {m_vill, m_vtype8} || vstart !== m_vstart[VLW-1:0]) begin
            $display("FAIL rand_state[%0d] instr=%h: got vl=%0d vtype=%h vstart=%0d want %0d/%h/%0d", it, ins, vl, vtype, vstart, m_vl, {m_vill, m_vtype8}, m_vstart);
         end else n_pass++;
      end
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_vsetvli();
      test_drain();
      test_csr();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
